// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with burst line refill over a req/gnt/beat bus.
// Optional performance counters are compiled in when ICACHE_PERF_CNT_EN is defined.
module inst_cache #(
    parameter int ADDR_W     = 32,
    parameter int INDEX_BITS = 6,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              im_r_en,
    input  logic [ADDR_W-1:0] im_addr,
    input  logic              im_flush,
    output logic              inst_cache_ready,
    output logic [31:0]       im_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]       perf_hit_cnt,
    output logic [31:0]       perf_miss_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int OFF_BITS = $clog2(LINE_WORDS);
    localparam int LINE_LSB = OFF_BITS + 2;
    localparam int TAG_W    = ADDR_W - INDEX_BITS - LINE_LSB;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(LINE_WORDS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] FILL = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [ADDR_W-1:0]   line_addr_q, line_addr_d;
    logic [OFF_BITS-1:0] cnt_q, cnt_d;
    logic                flushed_q, flushed_d;

    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [31:0]         data_q [LINES*LINE_WORDS];

    logic [INDEX_BITS-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0]      req_tag, fill_tag;
    logic [OFF_BITS-1:0]   req_off;
    logic                  hit, miss_start, beat_wr, last_beat;
    logic                  unused_addr_lsbs;

    assign req_idx  = im_addr[LINE_LSB +: INDEX_BITS];
    assign req_tag  = im_addr[ADDR_W-1 -: TAG_W];
    assign req_off  = im_addr[2 +: OFF_BITS];
    assign fill_idx = line_addr_q[LINE_LSB +: INDEX_BITS];
    assign fill_tag = line_addr_q[ADDR_W-1 -: TAG_W];
    assign unused_addr_lsbs = ^im_addr[1:0];

    assign hit        = (state_q == IDLE) & im_r_en & valid_q[req_idx]
                      & (tag_q[req_idx] == req_tag) & ~im_flush;
    assign miss_start = (state_q == IDLE) & im_r_en & ~hit & ~im_flush;
    assign beat_wr    = (state_q == FILL) & mem_rvalid;
    assign last_beat  = beat_wr & (cnt_q == LAST_BEAT);

    assign inst_cache_ready = hit;
    assign im_rdata         = hit ? data_q[{req_idx, req_off}] : '0;
    assign mem_req          = (state_q == REQ);
    assign mem_addr         = line_addr_q;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        line_addr_d = line_addr_q;
        cnt_d       = cnt_q;
        flushed_d   = flushed_q;
        case (state_q)
            IDLE: begin
                if (miss_start) begin
                    line_addr_d = {im_addr[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
                    flushed_d   = 1'b0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (beat_wr) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        if (!flushed_q && !im_flush) valid_d[fill_idx] = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A flush seen anywhere during a refill keeps the incoming line invalid.
        if (im_flush) begin
            valid_d   = '0;
            flushed_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            line_addr_q <= '0;
            cnt_q       <= '0;
            flushed_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            line_addr_q <= line_addr_d;
            cnt_q       <= cnt_d;
            flushed_q   <= flushed_d;
        end
    end

    always_ff @(posedge clk) begin
        if (beat_wr)   data_q[{fill_idx, cnt_q}] <= mem_rdata;
        if (last_beat) tag_q[fill_idx]           <= fill_tag;
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (hit)                           hit_cnt_q   <= hit_cnt_q + 32'd1;
            if (miss_start)                    miss_cnt_q  <= miss_cnt_q + 32'd1;
            if (im_r_en && !inst_cache_ready)  stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_hit_cnt   = hit_cnt_q;
    assign perf_miss_cnt  = miss_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
